// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order imem reads,
// tags each request with its PC and buffers returned words for the decoder.
module inst_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0100_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW  = $clog2(FIFO_DEPTH + 1);
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]    pc_q;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_cnt;
    logic [FW-1:0]  fifo_count;
    logic [TPW-1:0] tag_wr;
    logic [TPW-1:0] tag_rd;
    logic [FPW-1:0] fifo_wr;
    logic [FPW-1:0] fifo_rd;

    logic [31:0] tag_mem   [MAX_OUTSTANDING];
    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];

    logic req_fire;
    logic fifo_push;
    logic fifo_pop;

    function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
        return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
    endfunction

    function automatic logic [FPW-1:0] fifo_inc(input logic [FPW-1:0] p);
        return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + FPW'(1);
    endfunction

    // Every in-flight word already owns a buffer slot, so a response can always be pushed.
    assign imem_req_valid = !reset && !redirect_valid
                          && (int'(outstanding) < MAX_OUTSTANDING)
                          && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fifo_push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign inst_valid     = (fifo_count != '0) && !redirect_valid;
    assign fifo_pop       = inst_valid && inst_ready;
    assign inst           = (fifo_count != '0) ? fifo_data[fifo_rd] : '0;
    assign inst_pc        = (fifo_count != '0) ? fifo_pc[fifo_rd]   : '0;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            if (req_fire) begin
                pc_q   <= pc_q + 32'd4;
                tag_wr <= tag_inc(tag_wr);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_inc(tag_rd);
            end
            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase

            if (redirect_valid) begin
                // Everything still in flight after this edge is stale.
                pc_q       <= redirect_pc & ~32'd3;
                drop_cnt   <= outstanding - OW'(imem_rsp_valid);
                fifo_count <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
            end else begin
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
                if (fifo_push) begin
                    fifo_wr <= fifo_inc(fifo_wr);
                end
                if (fifo_pop) begin
                    fifo_rd <= fifo_inc(fifo_rd);
                end
                case ({fifo_push, fifo_pop})
                    2'b10:   fifo_count <= fifo_count + FW'(1);
                    2'b01:   fifo_count <= fifo_count - FW'(1);
                    default: ;
                endcase
            end
        end
    end

    // NOTE: storage arrays carry no reset; the occupancy counters alone decide validity.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr] <= pc_q;
        end
        if (fifo_push) begin
            fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
            fifo_data[fifo_wr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of in-flight and buffered words.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam int          MAX_OUT  = 2;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    inst_fetch #(
        .RESET_PC(RESET_PC),
        .MAX_OUTSTANDING(MAX_OUT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    req_t        pending[$];
    word_t       buffer[$];
    logic [31:0] dec_log[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_req;
    logic [31:0] redir_target;
    int          cyc;
    int          last_due;
    int          checks;
    int          errors;
    int          delivered;
    int          lat_min;
    int          lat_max;
    int          req_rdy_pct;
    int          dec_rdy_pct;
    bit          redir_req;
    bit          redir_on_rsp;
    bit          redir_hit;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic bit coin(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge,
    // then advance the model with the handshakes that the next rising edge commits.
    task automatic tick();
        bit    exp_rv;
        bit    exp_iv;
        word_t head;
        word_t w;
        req_t  r;
        int    lat;
        imem_req_ready = coin(req_rdy_pct);
        inst_ready     = coin(dec_rdy_pct);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
        end
        redirect_valid = redir_req || (redir_on_rsp && imem_rsp_valid);
        if (redir_on_rsp && imem_rsp_valid) begin
            redir_hit    = 1'b1;
            redir_on_rsp = 1'b0;
        end
        redirect_pc = redir_target;
        #4;
        exp_rv = !redirect_valid && pending.size() < MAX_OUT
                 && (pending.size() + buffer.size()) < DEPTH;
        exp_iv = buffer.size() != 0 && !redirect_valid;
        if (buffer.size() != 0) begin
            head = buffer[0];
        end else begin
            head.pc   = '0;
            head.data = '0;
        end
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, exp_req);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
        check("inst", inst, head.data);
        check("inst_pc", inst_pc, head.pc);

        if (exp_rv && imem_req_ready) begin
            lat       = int'($urandom_range(lat_max, lat_min));
            r.addr    = exp_req;
            r.due     = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            r.stale   = 1'b0;
            last_due  = r.due;
            pending.push_back(r);
            req_log.push_back(imem_req_addr);
            exp_req   = exp_req + 32'd4;
        end
        if (exp_iv && inst_ready) begin
            dec_log.push_back(inst_pc);
            w = buffer.pop_front();
            delivered++;
        end
        if (redirect_valid) begin
            for (int i = 0; i < pending.size(); i++) pending[i].stale = 1'b1;
            buffer.delete();
            dec_log.delete();
            req_log.delete();
            exp_req = redir_target & ~32'd3;
        end
        if (imem_rsp_valid) begin
            r = pending.pop_front();
            if (!r.stale) begin
                w.pc   = r.addr;
                w.data = mem_word(r.addr);
                buffer.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        redir_req = 1'b0;
    endtask

    task automatic clear_model();
        pending.delete();
        buffer.delete();
        dec_log.delete();
        req_log.delete();
        exp_req  = RESET_PC;
        last_due = 0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        checks = 0; errors = 0; cyc = 0; delivered = 0;
        redir_req = 1'b0; redir_on_rsp = 1'b0; redir_hit = 1'b0; redir_target = '0;
        lat_min = 1; lat_max = 1; req_rdy_pct = 100; dec_rdy_pct = 100;
        clear_model();
        #2;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming at latency 1 with both sides always ready.
        repeat (30) tick();
        check("t1_req0", req_log[0], 32'h0100_0000);
        check("t1_req1", req_log[1], 32'h0100_0004);
        check("t1_req2", req_log[2], 32'h0100_0008);
        check("t1_dec0", dec_log[0], 32'h0100_0000);
        check("t1_dec1", dec_log[1], 32'h0100_0004);
        check("t1_rate", {31'd0, delivered >= 15}, 32'd1);

        // Decoder stall: buffer fills, requests stop, nothing lost afterwards.
        dec_rdy_pct = 0;
        repeat (10) tick();
        check("t2_req_stopped", {31'd0, imem_req_valid}, 32'd0);
        check("t2_inst_held", {31'd0, inst_valid}, 32'd1);
        dec_rdy_pct = 100;
        repeat (20) tick();
        for (int i = 0; i < dec_log.size(); i++)
            check("t2_order", dec_log[i], RESET_PC + 32'(4 * i));

        // Redirect with two words in flight.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pending.size() != 2; i++) tick();
        redir_req = 1'b1; redir_target = 32'h0000_2002;
        tick();
        for (int i = 0; i < 30 && dec_log.size() == 0; i++) tick();
        check("t3_dec_pc", dec_log[0], 32'h0000_2000);
        check("t3_req_addr", req_log[0], 32'h0000_2000);

        // Redirect in the same cycle a response arrives.
        lat_min = 2; lat_max = 2;
        redir_target = 32'h0000_3000; redir_hit = 1'b0; redir_on_rsp = 1'b1;
        for (int i = 0; i < 20 && !redir_hit; i++) tick();
        check("t4_hit", {31'd0, redir_hit}, 32'd1);
        redir_on_rsp = 1'b0;
        for (int i = 0; i < 30 && dec_log.size() == 0; i++) tick();
        check("t4_dec_pc", dec_log[0], 32'h0000_3000);

        // Address wrap at the top of memory.
        lat_min = 1; lat_max = 2;
        redir_req = 1'b1; redir_target = 32'hFFFF_FFF8;
        tick();
        for (int i = 0; i < 40 && dec_log.size() < 3; i++) tick();
        check("t5_dec0", dec_log[0], 32'hFFFF_FFF8);
        check("t5_dec1", dec_log[1], 32'hFFFF_FFFC);
        check("t5_dec2", dec_log[2], 32'h0000_0000);
        check("t5_req2", req_log[2], 32'h0000_0000);

        // Asynchronous reset with a full buffer.
        dec_rdy_pct = 0; lat_min = 1; lat_max = 1;
        repeat (8) tick();
        check("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
        reset = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        check("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("t6_req_addr", imem_req_addr, RESET_PC);
        check("t6_inst", inst, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        dec_rdy_pct = 100;
        repeat (10) tick();
        check("t6_restart", dec_log[0], RESET_PC);

        // Randomized traffic with random redirects.
        lat_min = 1; lat_max = 3; req_rdy_pct = 70; dec_rdy_pct = 70;
        repeat (400) begin
            if (coin(4)) begin
                redir_req    = 1'b1;
                redir_target = $urandom;
            end
            tick();
        end
        req_rdy_pct = 100; dec_rdy_pct = 100;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
